// File: rtl/piano_tone_gen.sv
// piano_tone_gen
// Square-wave tone generator for the FPGA piano. Takes the eight note
// enables (C4..C5), picks the highest-pitched active note and drives one
// speaker pin. Pitch changes and note-off are only applied at half-period
// boundaries, so the speaker never sees a runt pulse.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high; clears all state at once
//   en[7:0]  - note enables, bit0=C4 .. bit7=C5 (asynchronous to clk)
//   tone     - square-wave speaker drive
//   active   - high while a note is sounding (PLAY or RELEASE)
//   note_idx - index of the sounding note; holds its value when idle
//   note_chg - one-cycle pulse in the cycle note_idx takes a new value
module piano_tone_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       en,
    output logic             tone,
    output logic             active,
    output logic [2:0]       note_idx,
    output logic             note_chg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Half-period in clock cycles for note idx, rounded to nearest.
    function automatic logic [CNT_W-1:0] half_cnt(input int idx);
        real f_hz;
        case (idx)
            0:       f_hz = 261.63;
            1:       f_hz = 293.66;
            2:       f_hz = 329.63;
            3:       f_hz = 349.23;
            4:       f_hz = 392.00;
            5:       f_hz = 440.00;
            6:       f_hz = 493.88;
            default: f_hz = 523.25;
        endcase
        return CNT_W'($rtoi(real'(CLK_HZ) / (2.0 * f_hz) + 0.5));
    endfunction

    localparam logic [CNT_W-1:0] HALF [8] = '{
        half_cnt(0), half_cnt(1), half_cnt(2), half_cnt(3),
        half_cnt(4), half_cnt(5), half_cnt(6), half_cnt(7)
    };

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       en_meta_r;
    logic [7:0]       en_sync_r;
    logic [2:0]       sel_s;
    logic             any_s;
    logic             boundary_s;
    logic [CNT_W-1:0] load_val_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tone_r;
    logic             tone_nxt_s;
    logic             active_r;
    logic             active_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic             chg_r;
    logic             chg_nxt_s;

    // Two-flop synchronizer for the asynchronous note enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_meta_r <= 8'h00;
            en_sync_r <= 8'h00;
        end else begin
            en_meta_r <= en;
            en_sync_r <= en_meta_r;
        end
    end

    // Priority select: the highest-pitched enabled note wins.
    always_comb begin
        sel_s = 3'd0;
        casez (en_sync_r)
            8'b1???????: sel_s = 3'd7;
            8'b01??????: sel_s = 3'd6;
            8'b001?????: sel_s = 3'd5;
            8'b0001????: sel_s = 3'd4;
            8'b00001???: sel_s = 3'd3;
            8'b000001??: sel_s = 3'd2;
            8'b0000001?: sel_s = 3'd1;
            default:     sel_s = 3'd0;
        endcase
    end

    assign any_s      = |en_sync_r;
    assign boundary_s = (cnt_r == {CNT_W{1'b0}});
    assign load_val_s = HALF[sel_s] - CNT_ONE;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (boundary_s) begin
                    state_nxt_s = any_s ? ST_PLAY : ST_IDLE;
                end else if (!any_s) begin
                    // A high phase must run to its boundary; a low one may stop now.
                    state_nxt_s = tone_r ? ST_RELEASE : ST_IDLE;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_RELEASE: begin
                if (boundary_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (any_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output / datapath next values (all registered below).
    always_comb begin
        cnt_nxt_s  = cnt_r;
        tone_nxt_s = tone_r;
        idx_nxt_s  = idx_r;
        chg_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    cnt_nxt_s  = load_val_s;
                    tone_nxt_s = 1'b1;
                    idx_nxt_s  = sel_s;
                    chg_nxt_s  = (sel_s != idx_r);
                end else begin
                    tone_nxt_s = 1'b0;
                end
            end
            ST_PLAY: begin
                if (boundary_s) begin
                    if (any_s) begin
                        tone_nxt_s = ~tone_r;
                        cnt_nxt_s  = load_val_s;
                        idx_nxt_s  = sel_s;
                        chg_nxt_s  = (sel_s != idx_r);
                    end else begin
                        // Either ends a high phase or suppresses the next one.
                        tone_nxt_s = 1'b0;
                    end
                end else if (!any_s && !tone_r) begin
                    // Straight to idle; cnt is reloaded on the next start.
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (boundary_s) begin
                    tone_nxt_s = 1'b0;
                end else begin
                    // Keep counting so a re-press resumes the same waveform.
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                tone_nxt_s = 1'b0;
            end
        endcase
        active_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            tone_r   <= 1'b0;
            active_r <= 1'b0;
            idx_r    <= 3'd0;
            chg_r    <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            tone_r   <= tone_nxt_s;
            active_r <= active_nxt_s;
            idx_r    <= idx_nxt_s;
            chg_r    <= chg_nxt_s;
        end
    end

    assign tone     = tone_r;
    assign active   = active_r;
    assign note_idx = idx_r;
    assign note_chg = chg_r;

endmodule

// File: tb/tb_piano_tone_gen.sv
// tb_piano_tone_gen
// Directed bench for piano_tone_gen. Runs the generator with CLK_HZ=100000
// so half-periods are short; the hand-rounded half-period counts at that
// clock are C4=191 D4=170 E4=152 F4=143 G4=128 A4=114 B4=101 C5=96.
// Outputs are sampled on the falling clock edge, inputs driven 1 time unit
// after the rising edge.
module tb_piano_tone_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] en;
    logic       tone;
    logic       active;
    logic [2:0] note_idx;
    logic       note_chg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piano_tone_gen #(
        .CLK_HZ(100_000),
        .CNT_W (17)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .tone    (tone),
        .active  (active),
        .note_idx(note_idx),
        .note_chg(note_chg)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_en(input logic [7:0] v);
        @(posedge clk);
        #1 en = v;
    endtask

    // Wait (bounded) until tone reaches lvl; ends on a falling edge.
    task automatic wait_tone(input logic lvl, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (tone !== lvl && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(tone), 32'(lvl));
    endtask

    // Wait (bounded) until active drops; ends on a falling edge.
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (active !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(active), 32'd0);
    endtask

    // Length of the current tone phase: n0 cycles already seen, count on
    // until tone changes. chg counts note_chg pulses up to and including
    // the first sample of the next phase.
    task automatic measure_phase(input int n0, output int n, output int chg);
        logic lvl;
        lvl = tone;
        n   = n0;
        chg = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            chg += int'(note_chg);
            if (tone !== lvl) break;
            n++;
        end
    endtask

    initial begin
        int n;
        int c;
        int csum;
        int hi_cnt;
        int act_cnt;

        en    = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_tone", 32'(tone), 32'd0);
        check_val("rst_active", 32'(active), 32'd0);
        check_val("rst_idx", 32'(note_idx), 32'd0);
        check_val("rst_chg", 32'(note_chg), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single note A4: 3-cycle latency then 114/114 phases.
        drive_en(8'h20);
        repeat (3) @(negedge clk);
        check_val("a4_latency", 32'(tone), 32'd0);
        @(negedge clk);
        check_val("a4_tone_on", 32'(tone), 32'd1);
        check_val("a4_active", 32'(active), 32'd1);
        check_val("a4_idx", 32'(note_idx), 32'd5);
        check_val("a4_chg_start", 32'(note_chg), 32'd1);
        measure_phase(1, n, c);
        csum = c;
        check_val("a4_hi1", 32'(n), 32'd114);
        measure_phase(1, n, c);
        csum += c;
        check_val("a4_lo1", 32'(n), 32'd114);
        measure_phase(1, n, c);
        csum += c;
        check_val("a4_hi2", 32'(n), 32'd114);
        check_val("a4_no_chg", 32'(csum), 32'd0);

        // Priority C5+B4 requested mid-phase: current phase completes.
        drive_en(8'hC0);
        @(negedge clk);
        measure_phase(2, n, c);
        check_val("pri_cur_phase", 32'(n), 32'd114);
        check_val("pri_chg", 32'(c), 32'd1);
        check_val("pri_idx", 32'(note_idx), 32'd7);
        measure_phase(1, n, c);
        check_val("pri_half1", 32'(n), 32'd96);
        measure_phase(1, n, c);
        check_val("pri_half2", 32'(n), 32'd96);

        // Glitch-free switch C4 -> G4 in the middle of a high phase.
        drive_en(8'h00);
        wait_idle("c5_off");
        check_val("c5_off_tone", 32'(tone), 32'd0);
        drive_en(8'h01);
        wait_tone(1'b1, "c4_on");
        check_val("c4_idx", 32'(note_idx), 32'd0);
        check_val("c4_chg", 32'(note_chg), 32'd1);
        repeat (50) @(negedge clk);
        drive_en(8'h10);
        @(negedge clk);
        measure_phase(52, n, c);
        check_val("sw_hold_hi", 32'(n), 32'd191);
        check_val("sw_chg", 32'(c), 32'd1);
        check_val("sw_idx", 32'(note_idx), 32'd4);
        measure_phase(1, n, c);
        check_val("sw_g4_lo", 32'(n), 32'd128);
        measure_phase(1, n, c);
        check_val("sw_g4_hi", 32'(n), 32'd128);

        // Note-off 20 cycles into an E4 high phase: high runs its full length.
        drive_en(8'h00);
        wait_idle("g4_off");
        drive_en(8'h04);
        wait_tone(1'b1, "e4_on");
        check_val("e4_idx", 32'(note_idx), 32'd2);
        repeat (20) @(negedge clk);
        drive_en(8'h00);
        @(negedge clk);
        measure_phase(22, n, c);
        check_val("off_hi_len", 32'(n), 32'd152);
        check_val("off_active", 32'(active), 32'd0);
        hi_cnt  = 0;
        act_cnt = 0;
        repeat (400) begin
            @(negedge clk);
            hi_cnt  += int'(tone);
            act_cnt += int'(active);
        end
        check_val("off_quiet_tone", 32'(hi_cnt), 32'd0);
        check_val("off_quiet_active", 32'(act_cnt), 32'd0);

        // Re-press F4 during RELEASE: waveform continues unchanged.
        drive_en(8'h08);
        wait_tone(1'b1, "f4_on");
        check_val("f4_idx", 32'(note_idx), 32'd3);
        repeat (10) @(negedge clk);
        drive_en(8'h00);
        @(negedge clk);
        repeat (5) @(negedge clk);
        check_val("rel_tone", 32'(tone), 32'd1);
        check_val("rel_active", 32'(active), 32'd1);
        drive_en(8'h08);
        @(negedge clk);
        measure_phase(18, n, c);
        check_val("rel_hi_len", 32'(n), 32'd143);
        check_val("rel_no_chg", 32'(c), 32'd0);
        check_val("rel_active_lo", 32'(active), 32'd1);
        measure_phase(1, n, c);
        check_val("rel_lo_len", 32'(n), 32'd143);

        // Asynchronous reset while tone is high.
        check_val("ar_pre_tone", 32'(tone), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("ar_tone", 32'(tone), 32'd0);
        check_val("ar_active", 32'(active), 32'd0);
        check_val("ar_idx", 32'(note_idx), 32'd0);
        en = 8'h01;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("ar_latency", 32'(tone), 32'd0);
        @(negedge clk);
        check_val("ar_tone_on", 32'(tone), 32'd1);
        check_val("ar_active_on", 32'(active), 32'd1);
        check_val("ar_no_chg", 32'(note_chg), 32'd0);

        drive_en(8'h00);
        wait_idle("final_off");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
